updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter; next generation of the team's 4-bit enable counter.
//  Adds width/modulus parameters, direction control, synchronous clear and parallel load.
//  Adds wrap/saturate mode, a terminal-count output and wrap/overflow flags.
//  Used as a general event/timebase counter feeding timers and sequencers.
// PARAMETERS
//  WIDTH    4             counter width in bits (>=2)
//  MAX      2**WIDTH-1    highest count value; legal range 0..MAX (1 <= MAX <= 2**WIDTH-1)
//  SATURATE 0             0: wrap at the bounds; 1: hold at the bound instead of wrapping
//  RST_VAL  0             value loaded into out by reset (must be <= MAX)
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  enable    in   1      count enable; one step per clk when high
//  clear     in   1      synchronous clear to 0
//  load      in   1      synchronous parallel load of load_val
//  load_val  in   WIDTH  load value
//  up_dn     in   1      direction: 1 = up, 0 = down
//  out       out  WIDTH  current count (registered)
//  tc        out  1      terminal count (combinational), see below
//  wrap      out  1      registered one-cycle pulse: a bound event occurred on the previous edge
//  ovf       out  1      sticky overflow flag (registered)
// BEHAVIOUR
//  Reset (reset=0, asynchronous, at any time, including mid-count):
//    out=RST_VAL, wrap=0, ovf=0. Release is sampled on the next rising clk edge.
//  Per-edge priority: clear > load > enable. With none asserted, out holds.
//    clear: out<=0, wrap<=0, ovf<=0.
//    load:  out<=load_val; if load_val>MAX then out<=MAX. wrap<=0; ovf unchanged.
//    enable, up_dn=1: if out==MAX then bound event, else out<=out+1.
//    enable, up_dn=0: if out==0 then bound event, else out<=out-1.
//  Bound event:
//    SATURATE=0: up wraps MAX->0, down wraps 0->MAX.
//    SATURATE=1: out holds at the bound.
//    In both modes: wrap<=1 for exactly one cycle, ovf<=1 (sticky until clear or reset).
//  wrap is 0 on every edge without a bound event. Back-to-back bound events keep wrap high
//    (possible with MAX small or with SATURATE=1 and enable held).
//  tc = enable & ((up_dn & out==MAX) | (~up_dn & out==0)); asserted when the next edge is a bound event.
//  Direction may change on any cycle; the new direction applies at that edge with no extra latency.
//  Latency: out changes 1 clk after a qualifying edge; wrap/ovf update on the same edge as out.
//  Arithmetic: modulo MAX+1, never 2**WIDTH. out never exceeds MAX.
//  MAX=2**WIDTH-1 behaves as a plain binary counter.
// TESTING (WIDTH=4, MAX=9, SATURATE=0, RST_VAL=0 unless noted)
//  1 reset=0 mid-count with out=6 -> out=0, wrap=0, ovf=0 immediately, without a clk edge.
//  2 enable=1, up_dn=1 for 12 edges from 0 -> 1..9,0,1,2. tc=1 while out=9.
//    wrap high the single cycle out=0; ovf=1 thereafter.
//  3 up_dn=0 from out=1 -> 0 then 9; wrap pulses after the 0->9 step.
//    Flip up_dn at out=5 -> next value is 6.
//  4 load=1, load_val=7 with enable=1 -> out=7 (load wins). load_val=14 -> out=9 (clamped).
//    clear=1 together with load=1 -> out=0, ovf=0.
//  5 SATURATE=1: count up to 9, hold enable 3 more edges -> out stays 9, wrap high 3 cycles, ovf=1.
//    Down at 0 -> stays 0.
//  6 RST_VAL=5, MAX=15: reset -> out=5. Count up to 15 -> 0 wraps as a plain 4-bit counter.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate mode,
// combinational terminal count, one-cycle wrap pulse and sticky overflow.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_atMax;
  logic             w_atZero;
  logic             w_bound;
  logic [WIDTH-1:0] w_stepVal;

  assign w_atMax  = (r_count == LP_MAX);
  assign w_atZero = (r_count == '0);
  assign w_bound  = enable & (up_dn ? w_atMax : w_atZero);

  // Next value for an enabled step; bounds wrap modulo MAX+1 or hold when saturating.
  always_comb begin
    w_stepVal = r_count;
    if (up_dn) begin
      if (w_atMax) w_stepVal = SATURATE ? LP_MAX : '0;
      else         w_stepVal = r_count + 1'b1;
    end else begin
      if (w_atZero) w_stepVal = SATURATE ? '0 : LP_MAX;
      else          w_stepVal = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= LP_RST;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      // Out-of-range loads clamp so the count never exceeds MAX.
      r_count <= (load_val > LP_MAX) ? LP_MAX : load_val;
      r_wrap  <= 1'b0;
    end else if (enable) begin
      r_count <= w_stepVal;
      r_wrap  <= w_bound;
      if (w_bound) r_ovf <= 1'b1;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign out  = r_count;
  assign tc   = w_bound;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap mode (MAX=9), saturate mode,
// and a full-range counter with a non-zero reset value.
module tb_updown_mod_counter;

  logic clk;
  logic rstA, rstBC;

  logic       enA, clrA, ldA, upA;
  logic [3:0] valA, outA;
  logic       tcA, wrapA, ovfA;

  logic       enB, clrB, ldB, upB;
  logic [3:0] valB, outB;
  logic       tcB, wrapB, ovfB;

  logic       enC, clrC, ldC, upC;
  logic [3:0] valC, outC;
  logic       tcC, wrapC, ovfC;

  int total;
  int bad;

  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .RST_VAL(0)) dutA (
    .clk(clk), .reset(rstA), .enable(enA), .clear(clrA), .load(ldA),
    .load_val(valA), .up_dn(upA), .out(outA), .tc(tcA), .wrap(wrapA), .ovf(ovfA)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .RST_VAL(0)) dutB (
    .clk(clk), .reset(rstBC), .enable(enB), .clear(clrB), .load(ldB),
    .load_val(valB), .up_dn(upB), .out(outB), .tc(tcB), .wrap(wrapB), .ovf(ovfB)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(1'b0), .RST_VAL(5)) dutC (
    .clk(clk), .reset(rstBC), .enable(enC), .clear(clrC), .load(ldC),
    .load_val(valC), .up_dn(upC), .out(outC), .tc(tcC), .wrap(wrapC), .ovf(ovfC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [3:0] expUp [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

  initial begin
    total = 0;
    bad   = 0;
    rstA = 1'b0; rstBC = 1'b0;
    {enA, clrA, ldA, upA} = '0; valA = '0;
    {enB, clrB, ldB, upB} = '0; valB = '0;
    {enC, clrC, ldC, upC} = '0; valC = '0;

    #7;
    checkOutput("A reset out", outA, 0);
    checkOutput("A reset wrap", wrapA, 0);
    checkOutput("A reset ovf", ovfA, 0);
    checkOutput("C reset out", outC, 5);
    #1;
    rstA = 1'b1; rstBC = 1'b1;

    // Async reset mid-count
    enA = 1'b1; upA = 1'b1;
    repeat (6) tick();
    checkOutput("A count to 6", outA, 6);
    enA = 1'b0;
    #2 rstA = 1'b0;
    #1;
    checkOutput("A async reset out", outA, 0);
    checkOutput("A async reset wrap", wrapA, 0);
    checkOutput("A async reset ovf", ovfA, 0);
    #1 rstA = 1'b1;

    // Count up through the MAX->0 wrap
    enA = 1'b1; upA = 1'b1;
    #1;
    checkOutput("A tc at 0 up", tcA, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("A up out step %0d", i), outA, expUp[i]);
      checkOutput($sformatf("A up wrap step %0d", i), wrapA, (i == 9) ? 1 : 0);
      checkOutput($sformatf("A up ovf step %0d", i), ovfA, (i >= 9) ? 1 : 0);
      checkOutput($sformatf("A up tc step %0d", i), tcA, (expUp[i] == 4'd9) ? 1 : 0);
    end

    // Count down through 0->MAX, then reverse direction at 5
    upA = 1'b0;
    tick(); checkOutput("A down to 1", outA, 1);
    tick(); checkOutput("A down to 0", outA, 0);
    checkOutput("A tc at 0 down", tcA, 1);
    checkOutput("A wrap after 1->0", wrapA, 0);
    tick(); checkOutput("A down wrap to 9", outA, 9);
    checkOutput("A wrap after 0->9", wrapA, 1);
    tick(); checkOutput("A down to 8", outA, 8);
    checkOutput("A wrap cleared", wrapA, 0);
    repeat (3) tick();
    checkOutput("A down to 5", outA, 5);
    upA = 1'b1;
    tick(); checkOutput("A flip to up", outA, 6);

    // Load priority, clamping, clear priority
    ldA = 1'b1; valA = 4'd7;
    tick();
    checkOutput("A load 7", outA, 7);
    checkOutput("A load keeps ovf", ovfA, 1);
    checkOutput("A load wrap", wrapA, 0);
    valA = 4'd14;
    tick();
    checkOutput("A load clamp", outA, 9);
    checkOutput("A tc at 9 up", tcA, 1);
    enA = 1'b0;
    #1;
    checkOutput("A tc disabled", tcA, 0);
    clrA = 1'b1;
    tick();
    checkOutput("A clear over load out", outA, 0);
    checkOutput("A clear over load ovf", ovfA, 0);
    clrA = 1'b0; ldA = 1'b0;

    // Saturating instance
    enB = 1'b1; upB = 1'b1;
    repeat (9) tick();
    checkOutput("B up to 9", outB, 9);
    checkOutput("B no wrap yet", wrapB, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("B hold out %0d", i), outB, 9);
      checkOutput($sformatf("B hold wrap %0d", i), wrapB, 1);
      checkOutput($sformatf("B hold ovf %0d", i), ovfB, 1);
    end
    enB = 1'b0;
    tick();
    checkOutput("B idle wrap", wrapB, 0);
    checkOutput("B idle ovf sticky", ovfB, 1);
    clrB = 1'b1;
    tick();
    checkOutput("B clear out", outB, 0);
    checkOutput("B clear ovf", ovfB, 0);
    clrB = 1'b0; enB = 1'b1; upB = 1'b0;
    tick();
    checkOutput("B down hold 0", outB, 0);
    checkOutput("B down wrap", wrapB, 1);
    checkOutput("B down ovf", ovfB, 1);
    enB = 1'b0;

    // Full-range instance with RST_VAL=5
    enC = 1'b1; upC = 1'b1;
    repeat (10) tick();
    checkOutput("C up to 15", outC, 15);
    checkOutput("C tc at 15", tcC, 1);
    tick();
    checkOutput("C wrap to 0", outC, 0);
    checkOutput("C wrap pulse", wrapC, 1);
    checkOutput("C ovf", ovfC, 1);
    enC = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
